// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use and mult/div decode stalls, taken-branch
// flush of IF/ID and ID/EX, plus a saturating count of PC-stalled cycles.
module hazard_stall_ctrl #(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             ip_clk,
   input  logic             ip_rst,
   input  logic             ip_ID_EX_MemRead,
   input  logic [4:0]       ip_ID_EX_dest,
   input  logic [4:0]       ip_DEC_RS,
   input  logic [4:0]       ip_DEC_RT,
   input  logic             ip_DEC_uses_rt,
   input  logic             ip_DEC_md_read,
   input  logic             ip_DEC_md_start,
   input  logic             ip_EX_md_start,
   input  logic             ip_EX_branch_taken,
   output logic             op_PC_write,
   output logic             op_IF_ID_write,
   output logic             op_IF_ID_flush,
   output logic             op_ID_EX_bubble,
   output logic             op_md_busy,
   output logic [CNT_W-1:0] op_stall_cycles
);

   localparam int MD_W = $clog2(MD_LAT + 1);
   localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT);

   logic [MD_W-1:0]  md_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic             lu_hazard;
   logic             md_hazard;

   // HI/LO become readable in the first cycle the counter is back at zero.
   always_ff @(posedge ip_clk or posedge ip_rst) begin
      if (ip_rst) begin
         md_cnt <= '0;
      end else if (ip_EX_md_start) begin
         md_cnt <= MD_LOAD;
      end else if (md_cnt != '0) begin
         md_cnt <= md_cnt - MD_W'(1);
      end
   end

   always_ff @(posedge ip_clk or posedge ip_rst) begin
      if (ip_rst) begin
         stall_cnt <= '0;
      end else if (!op_PC_write && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign op_md_busy      = (md_cnt != '0);
   assign op_stall_cycles = stall_cnt;

   always_comb begin
      lu_hazard = ip_ID_EX_MemRead && (ip_ID_EX_dest != 5'd0) &&
                  ((ip_ID_EX_dest == ip_DEC_RS) ||
                   (ip_DEC_uses_rt && (ip_ID_EX_dest == ip_DEC_RT)));
      md_hazard = op_md_busy && (ip_DEC_md_read || ip_DEC_md_start);
   end

   // A taken branch kills the decode instruction, so its stall request is moot.
   always_comb begin
      op_PC_write     = 1'b1;
      op_IF_ID_write  = 1'b1;
      op_IF_ID_flush  = 1'b0;
      op_ID_EX_bubble = 1'b0;
      if (ip_rst) begin
         op_PC_write = 1'b1;
      end else if (ip_EX_branch_taken) begin
         op_IF_ID_flush  = 1'b1;
         op_ID_EX_bubble = 1'b1;
      end else if (lu_hazard || md_hazard) begin
         op_PC_write     = 1'b0;
         op_IF_ID_write  = 1'b0;
         op_ID_EX_bubble = 1'b1;
      end
   end

endmodule
